icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller.
- Services the datapath's imemREN/imemaddr requests. Returns imemload with a same-cycle ihit on a hit.
- On a miss, runs a single-word fill from memory over the iREN/iwait handshake; the next cycle then hits.
- ihit gates every pipeline register enable, so a miss stalls the whole pipeline.

Parameters:
- SETS, 16, number of frames; power of two, at least 2.
- IDX_W, $clog2(SETS), index width, derived; not for override.
- TAG_W, 30-IDX_W, tag width, derived; not for override.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath fetch address; word-aligned, bits [1:0] ignored.
- ihit  out  1  request served this cycle; imemload valid.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address, bits [1:0] = 0.
- iwait  in  1  memory busy; fill data valid in the cycle iwait=0 while iREN=1.
- iload  in  32  memory read data.

Behaviour:
- Address split: tag = imemaddr[31:2+IDX_W]; index = imemaddr[1+IDX_W:2]; bits [1:0] unused.
- Per-frame storage: valid (1), tag (TAG_W), data (32). Only valid is reset; tag and data are don't-care until filled.
- Reset (async, nRST=0):
  - all valid bits cleared; FSM to IDLE.
  - ihit=0, iREN=0, iaddr=0, imemload=0 while in reset.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = imemREN & valid[index] & (tag[index]==addr tag).
  - On a hit: ihit=1 and imemload=data[index], combinational, same cycle.
  - On a miss (imemREN=1, no hit): capture {imemaddr[31:2],2'b00} into the fill-address register, go to FILL next cycle. ihit=0.
  - imemREN=0: ihit=0, imemload=0, no transition.
- FILL:
  - iREN=1 and iaddr=captured address, held constant for the whole state. ihit=0.
  - Each cycle with iwait=1: stay in FILL.
  - Cycle with iwait=0: write frame[captured index] <= {valid=1, captured tag, iload}; go to IDLE next cycle.
  - The fill completes even if imemREN drops or imemaddr changes mid-fill. The captured address always wins.
- Miss latency: the request cycle + N wait cycles + 1 completion cycle. A fresh hit appears on the following cycle, provided imemaddr still matches.
- Conflict: a fill to an occupied index overwrites the frame unconditionally. No write-back, since the cache is read-only.
- iREN is never asserted in IDLE. At most one fill is outstanding.
- Reset mid-FILL:
  - the fill is abandoned; the frame is not written; all frames are invalid; iREN drops asynchronously.
  - A late iwait=0 after reset release has no effect because the FSM is in IDLE.
- imemload outside a hit is 0, never X.
- No self-modifying-code coherence: instruction memory is never written while the cache holds it.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000040. Memory holds iwait=1 for 3 cycles, then iwait=0 with iload=0x2001000A.
  - Required: iREN=1 and iaddr=0x00000040 for exactly 4 cycles. One cycle later ihit=1 with imemload=0x2001000A.
- Warm hit: re-request 0x00000040 → ihit=1 in the same cycle, iREN stays 0.
- Conflict miss:
  - Stimulus: with 0x00000040 resident, request 0x00000440 (same index 0, different tag) with iload=0xDEADBEEF.
  - Required: miss and fill. A later request to 0x00000040 misses again.
- Idle:
  - Stimulus: imemREN=0 for 10 cycles with arbitrary imemaddr.
  - Required: ihit=0, iREN=0, imemload=0, no frame changes.
- Address change mid-fill:
  - Stimulus: miss on 0x00000008; during FILL switch imemaddr to 0x0000000C; release iwait=0 with iload=0x11111111.
  - Required: frame 2 is written with 0x11111111. The next cycle is a miss on 0x0000000C (index 3).
- Reset mid-fill:
  - Stimulus: assert nRST=0 during FILL for 0x00000010; release it, then drive iwait=0.
  - Required: iREN drops immediately. A following request to 0x00000010 misses, proving the frame was not written.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache.
// Same-cycle hits; single-word fill over iREN/iwait on a miss.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_n;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];

    logic [29:0]      faddr;
    logic [IDX_W-1:0] fidx;
    logic [TAG_W-1:0] ftag;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             capture;
    logic             done;
    logic             unused_lsb;

    assign idx  = imemaddr[1+IDX_W:2];
    assign tag  = imemaddr[31:2+IDX_W];
    assign fidx = faddr[IDX_W-1:0];
    assign ftag = faddr[29:IDX_W];

    assign unused_lsb = ^imemaddr[1:0];

    assign hit = (state == IDLE) && imemREN && valid[idx]
                 && (tags[idx] == tag);

    // Next state and handshake outputs; fill address is held in FILL.
    always_comb begin
        state_n  = state;
        capture  = 1'b0;
        done     = 1'b0;
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = data[idx];
                end else if (imemREN) begin
                    capture = 1'b1;
                    state_n = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {faddr, 2'b00};
                if (!iwait) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; reset abandons any fill in progress.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // Fill address captured on the missing request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        faddr <= '0;
        else if (capture) faddr <= imemaddr[31:2];
    end

    // Valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)     valid       <= '0;
        else if (done) valid[fidx] <= 1'b1;
    end

    // Tag and data arrays are not reset; valid guards them.
    always_ff @(posedge CLK) begin
        if (done) begin
            tags[fidx] <= ftag;
            data[fidx] <= iload;
        end
    end

endmodule
